score_sseg_driver: RTL and testbench

Time-multiplexed 4-digit seven-segment driver for the Basys3 score display. Consumes the two BCD digit pairs that the binary-to-BCD converters produce for each player's score, holds them in a frame-coherent shadow register, and scans them onto the shared active-low segment and anode lines. Inter-digit blanking suppresses ghosting. Optional leading-zero suppression applies to the tens digits.

---
 rtl/score_sseg_driver_if.sv | 25 ++
 rtl/score_sseg_driver.sv | 100 ++++++++++
 tb/tb_score_sseg_driver.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/score_sseg_driver_if.sv
// Display-side bundle for the score seven-segment driver: BCD score digits
// and the leading-zero control go in, multiplexed segment/anode lines come out.
interface score_sseg_driver_if;
    logic [3:0] p1_bcd0;
    logic [3:0] p1_bcd1;
    logic [3:0] p2_bcd0;
    logic [3:0] p2_bcd1;
    logic       blank_lz;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_start;

    // score source side
    modport master (
        output p1_bcd0, p1_bcd1, p2_bcd0, p2_bcd1, blank_lz,
        input  an, seg, dp, frame_start
    );

    // display driver side
    modport slave (
        input  p1_bcd0, p1_bcd1, p2_bcd0, p2_bcd1, blank_lz,
        output an, seg, dp, frame_start
    );
endinterface

// File: rtl/score_sseg_driver.sv
// Time-multiplexed 4-digit seven-segment driver. The four score digits are
// captured into a shadow register once per frame so a score update never
// tears the display; each digit slot begins with a dark window to suppress
// ghosting while the anode switches.
module score_sseg_driver #(
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLANK_CYCLES = 2000
) (
    input  logic                clk,
    input  logic                rst_n,
    score_sseg_driver_if.slave  bus
);
    localparam int CNT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    // shadow[idx]: 0 = P2 units, 1 = P2 tens, 2 = P1 units, 3 = P1 tens
    logic [3:0][3:0]  shadow;
    logic             load_pending;

    logic             wrap;
    logic             load;
    logic             lit;
    logic [3:0]       dig;
    logic             lz_blank;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b0111111;
        endcase
    endfunction

    // Slot/frame boundaries and per-slot display selection from current state.
    always_comb begin
        wrap     = (cnt == CNT_LAST);
        load     = load_pending | (wrap & (idx == 2'd3));
        lit      = (cnt >= CNT_BLANK);
        dig      = shadow[idx];
        // only tens positions (odd idx) may be suppressed
        lz_blank = bus.blank_lz & idx[0] & (dig == 4'd0);
    end

    // Slot counter and digit index; idx steps once per slot wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= 2'd0;
        end else if (wrap) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Frame-coherent shadow capture: first edge out of reset, then each 3->0 wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow          <= '0;
            load_pending    <= 1'b1;
            bus.frame_start <= 1'b0;
        end else begin
            bus.frame_start <= load;
            if (load) begin
                shadow       <= {bus.p1_bcd1, bus.p1_bcd0, bus.p2_bcd1, bus.p2_bcd0};
                load_pending <= 1'b0;
            end
        end
    end

    // Registered segment/anode/dp drive; dark during the slot's blanking window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.an  <= 4'b1111;
            bus.seg <= 7'b1111111;
            bus.dp  <= 1'b1;
        end else if (!lit) begin
            bus.an  <= 4'b1111;
            bus.seg <= 7'b1111111;
            bus.dp  <= 1'b1;
        end else begin
            bus.an  <= ~(4'b0001 << idx);
            bus.seg <= lz_blank ? 7'b1111111 : decode(dig);
            // decimal point separates the two scores
            bus.dp  <= (idx != 2'd2);
        end
    end
endmodule

// File: tb/tb_score_sseg_driver.sv
// Self-checking bench for score_sseg_driver with short slots (8 cycles,
// 2 dark). Expected per-cycle display words are queued a frame at a time
// and popped as the DUT output is sampled.
module tb_score_sseg_driver;
    localparam int DC = 8;
    localparam int BC = 2;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fs;
    } exp_t;

    logic clk;
    logic rst_n;
    score_sseg_driver_if bus();

    score_sseg_driver #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t exp_q[$];
    int   n_assert;
    int   n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'b1000000;
            4'd1:    seg_of = 7'b1111001;
            4'd2:    seg_of = 7'b0100100;
            4'd3:    seg_of = 7'b0110000;
            4'd4:    seg_of = 7'b0011001;
            4'd5:    seg_of = 7'b0010010;
            4'd6:    seg_of = 7'b0000010;
            4'd7:    seg_of = 7'b1111000;
            4'd8:    seg_of = 7'b0000000;
            4'd9:    seg_of = 7'b0010000;
            default: seg_of = 7'b0111111;
        endcase
    endfunction

    task automatic set_digits(input logic [3:0] t1, input logic [3:0] u1,
                              input logic [3:0] t2, input logic [3:0] u2);
        bus.p1_bcd1 = t1;
        bus.p1_bcd0 = u1;
        bus.p2_bcd1 = t2;
        bus.p2_bcd0 = u2;
    endtask

    // Queue one full frame of expected words for the given shadowed digits.
    task automatic push_frame(input logic [3:0] t1, input logic [3:0] u1,
                              input logic [3:0] t2, input logic [3:0] u2,
                              input logic lz, input logic first);
        logic [3:0] an_tab [4];
        logic [3:0] d_tab  [4];
        exp_t e;
        an_tab[0] = 4'b1110; an_tab[1] = 4'b1101;
        an_tab[2] = 4'b1011; an_tab[3] = 4'b0111;
        d_tab[0] = u2; d_tab[1] = t2; d_tab[2] = u1; d_tab[3] = t1;
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < DC; c++) begin
                if (c < BC) begin
                    e.an = 4'b1111; e.seg = 7'b1111111; e.dp = 1'b1;
                end else begin
                    e.an  = an_tab[s];
                    e.seg = (lz && (s == 1 || s == 3) && d_tab[s] == 4'd0)
                            ? 7'b1111111 : seg_of(d_tab[s]);
                    e.dp  = (s == 2) ? 1'b0 : 1'b1;
                end
                // pulse after the out-of-reset load, and after the closing wrap load
                e.fs = ((s == 0 && c == 0 && first) || (s == 3 && c == DC - 1));
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic run_cycles(input string name, input int n);
        exp_t e;
        exp_t obs;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            obs = {bus.an, bus.seg, bus.dp, bus.frame_start};
            n_assert++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL %s: scoreboard empty, got an=%b seg=%b dp=%b fs=%b",
                         name, obs.an, obs.seg, obs.dp, obs.fs);
            end else begin
                e = exp_q.pop_front();
                if (obs !== e) begin
                    n_fail++;
                    $display("FAIL %s cyc %0d: got an=%b seg=%b dp=%b fs=%b, want an=%b seg=%b dp=%b fs=%b",
                             name, i, obs.an, obs.seg, obs.dp, obs.fs, e.an, e.seg, e.dp, e.fs);
                end
            end
        end
    endtask

    task automatic check_dark(input string name);
        n_assert++;
        if ({bus.an, bus.seg, bus.dp, bus.frame_start} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL %s: got an=%b seg=%b dp=%b fs=%b, want an=1111 seg=1111111 dp=1 fs=0",
                     name, bus.an, bus.seg, bus.dp, bus.frame_start);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        bus.blank_lz = 1'b0;
        set_digits(4'd0, 4'd7, 4'd1, 4'd2);
        #2 rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_dark("reset_hold");
        end
        @(negedge clk);
        rst_n = 1'b1;
        push_frame(4'd0, 4'd7, 4'd1, 4'd2, 1'b0, 1'b1);
        run_cycles("first_frame_a", 10);
        // next frame's score, loaded only at the closing wrap
        set_digits(4'd1, 4'd2, 4'd3, 4'd4);
        run_cycles("first_frame_b", 22);
    endtask

    task automatic test_scan_order();
        push_frame(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 1'b0);
        run_cycles("scan_order", 32);
    endtask

    task automatic test_frame_coherence();
        push_frame(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 1'b0);
        run_cycles("coherence_old_a", 12);
        bus.p2_bcd0 = 4'd9;
        run_cycles("coherence_old_b", 20);
        push_frame(4'd1, 4'd2, 4'd3, 4'd9, 1'b0, 1'b0);
        run_cycles("coherence_new_a", 16);
        set_digits(4'd0, 4'd5, 4'd0, 4'd0);
        run_cycles("coherence_new_b", 16);
    endtask

    task automatic test_leading_zero();
        bus.blank_lz = 1'b1;
        push_frame(4'd0, 4'd5, 4'd0, 4'd0, 1'b1, 1'b0);
        run_cycles("lz_on", 32);
        bus.blank_lz = 1'b0;
        push_frame(4'd0, 4'd5, 4'd0, 4'd0, 1'b0, 1'b0);
        run_cycles("lz_off_a", 16);
        bus.p1_bcd0 = 4'hB;
        run_cycles("lz_off_b", 16);
    endtask

    task automatic test_invalid_bcd();
        push_frame(4'd0, 4'hB, 4'd0, 4'd0, 1'b0, 1'b0);
        run_cycles("invalid_bcd", 32);
    endtask

    task automatic test_mid_reset();
        push_frame(4'd0, 4'hB, 4'd0, 4'd0, 1'b0, 1'b0);
        // stops with state at idx=2, cnt=5 (digit lit)
        run_cycles("pre_reset", 21);
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        check_dark("mid_reset_async");
        set_digits(4'd6, 4'd8, 4'd5, 4'd3);
        @(posedge clk);
        #1;
        check_dark("mid_reset_hold");
        @(negedge clk);
        rst_n = 1'b1;
        push_frame(4'd6, 4'd8, 4'd5, 4'd3, 1'b0, 1'b1);
        run_cycles("post_reset", 32);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        test_reset();
        test_scan_order();
        test_frame_coherence();
        test_leading_zero();
        test_invalid_bcd();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end
endmodule
